// File: rtl/reset_sequencer.sv
// Staged power-on / soft reset sequencer.
// After the board reset button is released, NUM_OUT positive reset outputs
// are released in ascending order: bit 0 after POR_DELAY cycles, then one
// bit every STAGE_DELAY cycles. A debounced soft-reset request re-asserts a
// masked subset of the outputs, holds them, and re-sequences only that subset.
module reset_sequencer #(
  parameter int NUM_OUT     = 4,
  parameter int CNT_W       = 24,
  parameter int POR_DELAY   = 2_500_000,
  parameter int STAGE_DELAY = 65536,
  parameter int DEBOUNCE    = 16,
  parameter int SOFT_HOLD   = 1024
) (
  input  logic               clk_in,
  input  logic               reset_button_n,
  input  logic               soft_reset_req,
  input  logic [NUM_OUT-1:0] soft_reset_mask,
  output logic [NUM_OUT-1:0] reset_out,
  output logic               all_released,
  output logic               busy
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0]   POR_LAST   = CNT_W'(POR_DELAY - 1);
  localparam logic [CNT_W-1:0]   STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]   SOFT_LAST  = CNT_W'(SOFT_HOLD - 1);
  localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE);
  localparam logic [NUM_OUT-1:0] BIT0       = NUM_OUT'(1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_POR_WAIT,
    S_STAGE,
    S_RUN,
    S_SOFT_ASSERT,
    S_SOFT_WAIT_REL
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_OUT-1:0] reset_out_q;
  logic [NUM_OUT-1:0] rel_set_q;
  logic               all_rel_q;
  logic               busy_q;

  logic [1:0]         rel_sync_q;
  logic [1:0]         soft_sync_q;
  logic [DEB_W-1:0]   deb_cnt_q;
  logic [DEB_W-1:0]   deb_cnt_d;
  logic               deb_used_q;

  logic               soft_req_s;
  logic               deb_sat;
  logic               trigger;
  logic               por_tick;
  logic               por_hit;
  logic [NUM_OUT-1:0] por_out;
  logic [NUM_OUT-1:0] pending;
  logic [NUM_OUT-1:0] next_bit;
  logic [NUM_OUT-1:0] stage_out;
  logic               stage_last;

  assign soft_req_s = soft_sync_q[1];
  assign deb_sat    = (deb_cnt_q == DEB_MAX);

  // A saturated request that was already seen in RUN (acted on or ignored
  // because the mask was empty) must drop before it can trigger again.
  assign trigger = (state_q == S_RUN) && deb_sat && !deb_used_q && (soft_reset_mask != '0);

  // The cycle that leaves HOLD counts as the first power-on delay cycle, so
  // bit 0 clears exactly POR_DELAY edges after the synchroniser output rises.
  // HOLD always carries a zero counter, so the same compare serves both states.
  assign por_tick = (state_q == S_POR_WAIT) || rel_sync_q[1];
  assign por_hit  = (cnt_q == POR_LAST);
  assign por_out  = reset_out_q & ~BIT0;

  // Lowest still-asserted bit of the active release set; releasing it is one
  // stage step. Bits outside the set are skipped without spending cycles.
  assign pending    = reset_out_q & rel_set_q;
  assign next_bit   = pending & (~pending + NUM_OUT'(1));
  assign stage_out  = reset_out_q & ~next_bit;
  assign stage_last = ((pending & ~next_bit) == '0);

  // Next debounce count: run length of the synchronised request, saturating.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (!soft_req_s) begin
      deb_cnt_d = '0;
    end else if (!deb_sat) begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  // Two-flop synchronisers for the button release and the soft request.
  always_ff @(posedge clk_in or negedge reset_button_n) begin
    if (!reset_button_n) begin
      rel_sync_q  <= '0;
      soft_sync_q <= '0;
    end else begin
      rel_sync_q  <= {rel_sync_q[0], 1'b1};
      soft_sync_q <= {soft_sync_q[0], soft_reset_req};
    end
  end

  // Debounce counter and the "this request was already consumed" flag.
  always_ff @(posedge clk_in or negedge reset_button_n) begin
    if (!reset_button_n) begin
      deb_cnt_q  <= '0;
      deb_used_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      if (!soft_req_s) begin
        deb_used_q <= 1'b0;
      end else if ((state_q == S_RUN) && deb_sat) begin
        deb_used_q <= 1'b1;
      end
    end
  end

  // Sequencer FSM with registered reset outputs and status flags.
  always_ff @(posedge clk_in or negedge reset_button_n) begin
    if (!reset_button_n) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      reset_out_q <= '1;
      rel_set_q   <= '1;
      all_rel_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        S_HOLD, S_POR_WAIT: begin
          if (por_tick) begin
            if (por_hit) begin
              reset_out_q <= por_out;
              cnt_q       <= '0;
              if (por_out == '0) begin
                state_q   <= S_RUN;
                all_rel_q <= 1'b1;
                busy_q    <= 1'b0;
              end else begin
                state_q <= S_STAGE;
              end
            end else begin
              state_q <= S_POR_WAIT;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
        end

        S_STAGE: begin
          if (cnt_q == STAGE_LAST) begin
            reset_out_q <= stage_out;
            cnt_q       <= '0;
            if (stage_last) begin
              state_q   <= S_RUN;
              all_rel_q <= (stage_out == '0);
              busy_q    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (trigger) begin
            rel_set_q   <= soft_reset_mask;
            reset_out_q <= reset_out_q | soft_reset_mask;
            all_rel_q   <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_SOFT_ASSERT;
          end
        end

        S_SOFT_ASSERT: begin
          if (cnt_q == SOFT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_SOFT_WAIT_REL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_SOFT_WAIT_REL: begin
          if (!soft_req_s) begin
            cnt_q   <= '0;
            state_q <= S_STAGE;
          end
        end

        default: begin
          state_q     <= S_HOLD;
          cnt_q       <= '0;
          reset_out_q <= '1;
          rel_set_q   <= '1;
          all_rel_q   <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign reset_out    = reset_out_q;
  assign all_released = all_rel_q;
  assign busy         = busy_q;

endmodule
